seven_seg_scan: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 15 +
 rtl/seven_seg_lut.sv | 9 +
 rtl/seven_seg_scan.sv | 81 ++++++++
 tb/tb_seven_seg_scan.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared code constants, glyph table and segment type for the scanned display
package seven_seg_pkg;
  typedef logic [7:0] seg_t;
  localparam logic [4:0] CODE_H = 5'h0A, CODE_E = 5'h0B, CODE_L = 5'h0C, CODE_O = 5'h0D, CODE_BLANK = 5'h1F;
  localparam int DP_BIT = 4;
  localparam seg_t SEG_BLANK = 8'hFF;
  // active-low a..g; entries 10-13 are the letters H,E,L,O
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b1001000, 7'b0110000, 7'b1110001, 7'b0000001, 7'b1111111, 7'b1111111};
  function automatic logic code_valid(input logic [4:0] c);
    return c[DP_BIT] ? c[3:0] <= 4'd9 : c[3:0] <= CODE_O[3:0];
  endfunction
endpackage

// File: rtl/seven_seg_lut.sv
// seven_seg_lut: combinational 5-bit digit code to active-low 8-bit segment map
module seven_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [4:0] code,
  output seg_t       seg
);
  assign seg = code_valid(code) ? {GLYPH[code[3:0]], ~code[DP_BIT]} : SEG_BLANK;
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed multi-digit display driver with frame-boundary buffer commit
// Optional per-digit blink enabled by defining SEVEN_SEG_BLINK_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    power,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [5*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   anodes
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [4:0]    active [NUM_DIGITS];
  logic [4:0]    shadow [NUM_DIGITS];
  logic          pending, last_cnt, wrap, gap, hide;
  seg_t          lut_seg;
  assign last_cnt   = scan_cnt == CNT_LAST;
  assign wrap       = power && last_cnt && idx == IDX_LAST;
  assign gap        = !power || scan_cnt == '0;
  assign load_ready = !pending;
  seven_seg_lut u_lut (.code(active[idx]), .seg(lut_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      segments <= SEG_BLANK;
      anodes   <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= CODE_BLANK;
        shadow[i] <= CODE_BLANK;
      end
    end else begin
      scan_cnt <= !power || last_cnt ? '0 : scan_cnt + 1'b1;
      idx      <= !power ? '0 : last_cnt ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
      segments <= gap || hide ? SEG_BLANK : lut_seg;
      anodes   <= gap ? '1 : ~(NUM_DIGITS'(1) << idx);
      // commit only at a frame wrap (or while dark) so a frame never mixes buffers
      if (load_valid && load_ready) begin
        for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= load_data[5*i +: 5];
        pending <= 1'b1;
      end else if (pending && (wrap || !power)) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end
`ifdef SEVEN_SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      frame_cnt   <= frame_cnt == FRAME_LAST ? '0 : frame_cnt + 1'b1;
      blink_phase <= blink_phase ^ (frame_cnt == FRAME_LAST);
    end
  end
  assign hide = blink_phase & blink_mask[idx];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
  assign hide = 1'b0;
`endif
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan (4 digits, 4-cycle slots, 2-frame blink)
module tb_seven_seg_scan;
  localparam int N = 4, SD = 4, BD = 2, FL = N * SD;
  logic        clk = 1'b0;
  logic        rst, power, load_valid, load_ready;
  logic [19:0] load_data;
  logic [3:0]  blink_mask, anodes;
  logic [7:0]  segments;
  typedef struct packed { logic [7:0] seg; logic [3:0] an; logic rdy; } exp_t;
  exp_t        sb [$];
  int          checks = 0, errors = 0;
  int          t, m_frames;
  logic [4:0]  m_act [N];
  logic [4:0]  m_sh [N];
  logic        m_pend, x;

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .power(power), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blink_mask(blink_mask), .segments(segments), .anodes(anodes));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec(input logic [4:0] c);
    logic [6:0] p;
    case (c[3:0])
      4'd0: p = 7'b0000001; 4'd1: p = 7'b1001111; 4'd2: p = 7'b0010010; 4'd3: p = 7'b0000110;
      4'd4: p = 7'b1001100; 4'd5: p = 7'b0100100; 4'd6: p = 7'b0100000; 4'd7: p = 7'b0001111;
      4'd8: p = 7'b0000000; 4'd9: p = 7'b0000100; 4'd10: p = 7'b1001000; 4'd11: p = 7'b0110000;
      4'd12: p = 7'b1110001; 4'd13: p = 7'b0000001; default: p = 7'b1111111;
    endcase
    if (c > 5'h19 || (c > 5'h0D && c < 5'h10)) return 8'hFF;
    return {p, ~c[4]};
  endfunction

  task automatic model_reset();
    t = 0; m_frames = 0; m_pend = 1'b0;
    for (int i = 0; i < N; i++) begin m_act[i] = 5'h1F; m_sh[i] = 5'h1F; end
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(segments), 32'hFF);
    chk("rst_an", 32'(anodes), 32'hF);
    chk("rst_rdy", 32'(load_ready), 32'h1);
    rst = 1'b0;
    model_reset();
  endtask

  // one clock: drive inputs, predict the registered outputs, then compare after the edge
  task automatic cycle(input logic pw, input logic lv, input logic [19:0] ld, output logic xfer);
    exp_t e, g;
    int pos, d;
    logic hid;
    power = pw; load_valid = lv; load_data = ld;
    pos = t % SD; d = (t / SD) % N; hid = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    hid = ((m_frames / BD) % 2 == 1) && blink_mask[d];
`endif
    e.seg = (!pw || pos == 0 || hid) ? 8'hFF : dec(m_act[d]);
    e.an  = (!pw || pos == 0) ? 4'hF : ~(4'b0001 << d);
    xfer = lv && !m_pend;
    if (xfer) begin
      for (int i = 0; i < N; i++) m_sh[i] = ld[5*i +: 5];
      m_pend = 1'b1;
    end else if (m_pend && (!pw || t % FL == FL - 1)) begin
      m_act = m_sh; m_pend = 1'b0;
    end
    if (pw && t % FL == FL - 1) m_frames++;
    t = pw ? t + 1 : 0;
    e.rdy = !m_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("seg", 32'(segments), 32'(g.seg));
    chk("an", 32'(anodes), 32'(g.an));
    chk("rdy", 32'(load_ready), 32'(g.rdy));
  endtask

  task automatic idle(input int n, input logic pw);
    for (int i = 0; i < n; i++) cycle(pw, 1'b0, 20'h0, x);
  endtask

  task automatic offer(input logic [19:0] ld);
    int k = 0;
    do begin cycle(1'b1, 1'b1, ld, x); k++; end while (!x && k < 100);
    if (!x) chk("offer_timeout", 32'(k), 32'(0));
  endtask

  initial begin
    rst = 1'b1; power = 1'b1; load_valid = 1'b0; load_data = '0; blink_mask = '0;
    do_reset();
    idle(2, 1'b1);
    offer({5'h0D, 5'h0C, 5'h0B, 5'h0A});
    idle(40, 1'b1);
    offer({5'h19, 5'h1E, 5'h13, 5'h05});
    idle(36, 1'b1);
    // second load held valid across the commit cycle
    offer({5'h01, 5'h02, 5'h03, 5'h04});
    offer({5'h10, 5'h11, 5'h12, 5'h0E});
    idle(40, 1'b1);
    idle(5, 1'b1);
    offer({5'h06, 5'h07, 5'h08, 5'h09});
    idle(3, 1'b0);
    idle(20, 1'b1);
    offer({5'h0C, 5'h0D, 5'h14, 5'h15});
    cycle(1'b1, 1'b1, {5'h16, 5'h17, 5'h18, 5'h00}, x);
    idle(36, 1'b1);
    // reset while a load is pending throws the shadow away
    offer({5'h0A, 5'h0A, 5'h0A, 5'h0A});
    idle(3, 1'b1);
    do_reset();
    idle(20, 1'b1);
    blink_mask = 4'b0010;
    do_reset();
    offer({5'h0D, 5'h0C, 5'h13, 5'h0A});
    idle(7 * FL, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
